// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
// Provides the state type and default operand/digit sizes.
package bcd_pkg;

  localparam int BCD_WIDTH  = 8;
  localparam int BCD_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5..9.
// Ports: in_nib (4-bit digit in), out_nib (4-bit corrected digit out).
module bcd_add3_cell (
  input  logic [3:0] in_nib,
  output logic [3:0] out_nib
);

  // Codes 10..15 are not legal digits; they map to 0.
  always_comb begin
    out_nib = 4'd0;
    unique case (1'b1)
      (in_nib < 4'd5):
        out_nib = in_nib;
      (in_nib >= 4'd5 && in_nib <= 4'd9):
        out_nib = in_nib + 4'd3;
      (in_nib > 4'd9):
        out_nib = 4'd0;
      default:
        out_nib = 4'd0;
    endcase
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Ports: clk, rst (sync, active high), start, bin_in -> busy, done, bcd_out.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sreg_q, sreg_d;
  logic [BW-1:0]   bcd_q, bcd_d;

  logic [BW-1:0]   adj;
  logic [SW-1:0]   shifted;

  for (genvar d = 0; d < DIGITS; d++) begin : g_cell
    bcd_add3_cell u_cell (
      .in_nib  (sreg_q[WIDTH + 4*d +: 4]),
      .out_nib (adj[4*d +: 4])
    );
  end

  // Correct all digits, then shift; binary MSB enters BCD bit 0.
  always_comb begin
    shifted = {adj, sreg_q[WIDTH-1:0]} << 1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = {{BW{1'b0}}, bin_in};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = shifted;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bcd_d   = shifted[SW-1 -: BW];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table plus multi-cycle corners.
// Drives on negedge, samples on negedge after each rising edge.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Present start with v for one edge, then scramble bin_in.
  task automatic kick(input logic [7:0] v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = ~v;
  endtask

  // Watch 14 cycles after the accepting edge; optional start pulse.
  task automatic observe(input int pulse_at, input logic [7:0] pv,
                         output int done_at, output int n_done,
                         output int n_busy, output logic [11:0] res);
    done_at = 0;
    n_done  = 0;
    n_busy  = 0;
    res     = 'x;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_at == 0) begin
          done_at = i;
          res     = bcd_out;
        end
      end
      if (i == pulse_at) begin
        start  = 1'b1;
        bin_in = pv;
      end else if (i == pulse_at + 1) begin
        start  = 1'b0;
      end
    end
  endtask

  int          d_at, n_d, n_b;
  logic [11:0] res;
  logic [7:0]  hv;
  int          stray;

  initial begin
    vecs[0]  = '{8'd0,   12'h000};
    vecs[1]  = '{8'd255, 12'h255};
    vecs[2]  = '{8'd99,  12'h099};
    vecs[3]  = '{8'd5,   12'h005};
    vecs[4]  = '{8'd200, 12'h200};
    vecs[5]  = '{8'd128, 12'h128};
    vecs[6]  = '{8'd17,  12'h017};
    vecs[7]  = '{8'd10,  12'h010};
    vecs[8]  = '{8'd9,   12'h009};
    vecs[9]  = '{8'd100, 12'h100};
    vecs[10] = '{8'd199, 12'h199};
    vecs[11] = '{8'd50,  12'h050};

    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[k]) begin
      kick(vecs[k].v);
      observe(0, 8'd0, d_at, n_d, n_b, res);
      chk($sformatf("vec%0d_bcd", k), 32'(res), 32'(vecs[k].exp));
      chk($sformatf("vec%0d_lat", k), 32'(d_at), 32'd9);
      chk($sformatf("vec%0d_busy", k), 32'(n_b), 32'd9);
      chk($sformatf("vec%0d_ndone", k), 32'(n_d), 32'd1);
      chk($sformatf("vec%0d_hold", k), 32'(bcd_out), 32'(vecs[k].exp));
    end

    // Start pulse with 17 during SHIFT must be ignored.
    kick(8'd200);
    observe(3, 8'd17, d_at, n_d, n_b, res);
    chk("ign_bcd", 32'(res), 32'h200);
    chk("ign_ndone", 32'(n_d), 32'd1);
    chk("ign_busy", 32'(n_b), 32'd9);
    chk("ign_hold", 32'(bcd_out), 32'h200);

    // Start held high with bin_in changing every cycle.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd11;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c % 10 == 8) begin
        hv = 8'(((c - 8) * 37 + 11) & 255);
        chk($sformatf("b2b_done%0d", c), 32'(done), 32'd1);
        chk($sformatf("b2b_bcd%0d", c), 32'(bcd_out),
            32'(to_bcd(int'(hv))));
      end else begin
        chk($sformatf("b2b_nodone%0d", c), 32'(done), 32'd0);
      end
      bin_in = 8'((((c + 1) * 37) + 11) & 255);
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset overrides start in the same cycle.
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 8'd55;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'd0);

    // Give bcd_out a nonzero value, then abort 128 mid-conversion.
    kick(8'd77);
    observe(0, 8'd0, d_at, n_d, n_b, res);
    chk("pre_abort_bcd", 32'(bcd_out), 32'h077);
    kick(8'd128);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'h000);
    rst   = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk("abort_quiet", 32'(stray), 32'd0);
    kick(8'd128);
    observe(0, 8'd0, d_at, n_d, n_b, res);
    chk("post_abort_bcd", 32'(res), 32'h128);
    chk("post_abort_lat", 32'(d_at), 32'd9);

    // Exhaustive sweep against the division-based model.
    for (int v = 0; v < 256; v++) begin
      kick(8'(v));
      observe(0, 8'd0, d_at, n_d, n_b, res);
      chk($sformatf("sweep%0d_bcd", v), 32'(res), 32'(to_bcd(v)));
      chk($sformatf("sweep%0d_lat", v), 32'(d_at), 32'd9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
